// File: rtl/router_pkg.sv
// Shared types and constants for the router output scheduler.
package router_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   localparam int NPORT       = 3;
   localparam int TIMEOUT_DEF = 30;

   // Header byte layout: address in the low bits, payload length above it.
   localparam int HDR_ADDR_W  = 2;
   localparam int HDR_LEN_W   = 6;
   localparam int HDR_LEN_LSB = HDR_ADDR_W;

   // Grant value reported while no port is owned.
   localparam logic [1:0] GRANT_IDLE = 2'd3;

   // Payload length field of a header byte.
   function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
      return hdr[HDR_LEN_LSB +: HDR_LEN_W];
   endfunction

   // Next port index in round-robin order (wraps 2 -> 0).
   function automatic logic [1:0] next_port(input logic [1:0] p);
      logic [1:0] n;
      case (p)
         2'd0:    n = 2'd1;
         2'd1:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/router_out_sched_if.sv
// Merged output byte stream of the router output scheduler.
interface router_out_sched_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_sop;
   logic       m_eop;

   modport master (output m_data, output m_valid, output m_sop, output m_eop, input m_ready);
   modport slave  (input m_data, input m_valid, input m_sop, input m_eop, output m_ready);
endinterface

// File: rtl/router_rr_arb.sv
// Three-request round-robin picker: first requester at or after ptr wins.
module router_rr_arb (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld
);
   import router_pkg::*;

   logic [1:0] p0_s;
   logic [1:0] p1_s;
   logic [1:0] p2_s;

   // Walk the ports in pointer order and pick the first one requesting.
   always_comb begin
      p0_s    = (ptr == 2'd3) ? 2'd0 : ptr;
      p1_s    = next_port(p0_s);
      p2_s    = next_port(p1_s);
      gnt_idx = GRANT_IDLE;
      gnt_vld = 1'b0;
      if (req[p0_s]) begin
         gnt_idx = p0_s;
         gnt_vld = 1'b1;
      end else if (req[p1_s]) begin
         gnt_idx = p1_s;
         gnt_vld = 1'b1;
      end else if (req[p2_s]) begin
         gnt_idx = p2_s;
         gnt_vld = 1'b1;
      end else begin
         gnt_idx = GRANT_IDLE;
         gnt_vld = 1'b0;
      end
   end

endmodule

// File: rtl/router_out_sched.sv
// Drains whole packets from three router FIFOs onto one byte stream,
// round-robin between ports, with a mid-packet starvation timeout.
module router_out_sched #(
   parameter int TIMEOUT = router_pkg::TIMEOUT_DEF,
   parameter int NPORT   = router_pkg::NPORT
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [NPORT-1:0] valid_out,
   input  logic [7:0]       data_out_0,
   input  logic [7:0]       data_out_1,
   input  logic [7:0]       data_out_2,
   output logic [NPORT-1:0] read_enb,
   output logic [1:0]       grant,
   output logic             timeout_err,
   router_out_sched_if.master m_if
);
   import router_pkg::*;

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]    grant_q, grant_d;
   logic [6:0]    bytes_left_q, bytes_left_d;
   logic          first_q, first_d;        // next arriving byte is the header
   logic          inflight_q, inflight_d;  // a read was issued last cycle
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]    m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_sop_q, m_sop_d;
   logic          m_eop_q, m_eop_d;
   logic          timeout_err_q, timeout_err_d;

   logic [1:0]       arb_idx_s;
   logic             arb_vld_s;
   logic             valid_gnt_s;
   logic [7:0]       byte_s;
   logic             accept_s;
   logic             rd_s;
   logic [NPORT-1:0] rd_vec_s;

   router_rr_arb u_arb (
      .req     (valid_out),
      .ptr     (rr_ptr_q),
      .gnt_idx (arb_idx_s),
      .gnt_vld (arb_vld_s)
   );

   // Select not-empty flag and read data of the owned port.
   always_comb begin
      case (grant_q)
         2'd0: begin valid_gnt_s = valid_out[0]; byte_s = data_out_0; end
         2'd1: begin valid_gnt_s = valid_out[1]; byte_s = data_out_1; end
         2'd2: begin valid_gnt_s = valid_out[2]; byte_s = data_out_2; end
         default: begin valid_gnt_s = 1'b0; byte_s = 8'h00; end
      endcase
   end

   // Next-state logic: arbitration, read issue, byte tracking, timeout.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = grant_q;
      bytes_left_d  = bytes_left_q;
      first_d       = first_q;
      inflight_d    = 1'b0;
      tmo_cnt_d     = tmo_cnt_q;
      m_data_d      = m_data_q;
      m_valid_d     = m_valid_q;
      m_sop_d       = m_sop_q;
      m_eop_d       = m_eop_q;
      timeout_err_d = 1'b0;
      rd_s          = 1'b0;
      accept_s      = m_valid_q && m_if.m_ready;

      // Output register: a byte read last cycle lands here; otherwise drain on accept.
      if (inflight_q) begin
         m_data_d  = byte_s;
         m_valid_d = 1'b1;
         m_sop_d   = first_q;
         m_eop_d   = !first_q && (bytes_left_q == 7'd1);
      end else if (accept_s) begin
         m_valid_d = 1'b0;
         m_sop_d   = 1'b0;
         m_eop_d   = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (arb_vld_s) begin
               state_d      = ST_XFER;
               grant_d      = arb_idx_s;
               bytes_left_d = 7'd1;
               first_d      = 1'b1;
               tmo_cnt_d    = '0;
            end else begin
               grant_d = GRANT_IDLE;
            end
         end
         ST_XFER: begin
            if (inflight_q) begin
               if (first_q) begin
                  bytes_left_d = {1'b0, hdr_len(byte_s)} + 7'd1;
                  first_d      = 1'b0;
               end else begin
                  bytes_left_d = bytes_left_q - 7'd1;
               end
            end else begin
               bytes_left_d = bytes_left_q;
            end

            rd_s = valid_gnt_s && (bytes_left_q != 7'd0) && !inflight_q &&
                   (!m_valid_q || m_if.m_ready);

            if (rd_s) begin
               inflight_d = 1'b1;
               tmo_cnt_d  = '0;
            end else if ((bytes_left_q != 7'd0) && !valid_gnt_s) begin
               if (tmo_cnt_q == TMO_LAST) begin
                  // Starved too long: drop ownership, the output byte still drains.
                  state_d       = ST_IDLE;
                  grant_d       = GRANT_IDLE;
                  rr_ptr_d      = next_port(grant_q);
                  bytes_left_d  = 7'd0;
                  first_d       = 1'b0;
                  tmo_cnt_d     = '0;
                  timeout_err_d = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TW'(1);
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q;
            end

            if (accept_s && m_eop_q) begin
               state_d      = ST_IDLE;
               grant_d      = GRANT_IDLE;
               rr_ptr_d     = next_port(grant_q);
               bytes_left_d = 7'd0;
               first_d      = 1'b0;
               tmo_cnt_d    = '0;
            end else begin
               state_d = state_d;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = GRANT_IDLE;
         end
      endcase

      rd_vec_s = rd_s ? (NPORT'(1) << grant_q) : '0;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= 2'd0;
         grant_q       <= GRANT_IDLE;
         bytes_left_q  <= 7'd0;
         first_q       <= 1'b0;
         inflight_q    <= 1'b0;
         tmo_cnt_q     <= '0;
         m_data_q      <= 8'h00;
         m_valid_q     <= 1'b0;
         m_sop_q       <= 1'b0;
         m_eop_q       <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         bytes_left_q  <= bytes_left_d;
         first_q       <= first_d;
         inflight_q    <= inflight_d;
         tmo_cnt_q     <= tmo_cnt_d;
         m_data_q      <= m_data_d;
         m_valid_q     <= m_valid_d;
         m_sop_q       <= m_sop_d;
         m_eop_q       <= m_eop_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign read_enb     = rd_vec_s;
   assign grant        = grant_q;
   assign timeout_err  = timeout_err_q;
   assign m_if.m_data  = m_data_q;
   assign m_if.m_valid = m_valid_q;
   assign m_if.m_sop   = m_sop_q;
   assign m_if.m_eop   = m_eop_q;

endmodule
